step_sched: RTL and testbench

Step scheduler and mode sequencer for the switched state-space solver. It generates the periodic one-cycle `step` pulse that launches each compute iteration and latches the switch state (on/off matrix set) for that iteration. It swaps coefficient banks only at step boundaries, watches `comp_ready` for completion, and flags and counts overruns. It sits between the host/config registers, the PWM gate source and `compute_blk`.

---
 rtl/step_sched_pkg.sv | 16 +
 rtl/step_sched_sync_ff.sv | 31 +++
 rtl/step_sched.sv | 180 ++++++++++++++++++
 tb/tb_step_sched.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/step_sched_pkg.sv
// Shared definitions for the step scheduler.
//
// Contents:
//   ss_state_e   - sequencer state encoding (idle, waiting for a tick, iteration in flight)
//   SsPeriodMin  - smallest usable step period in clocks; shorter requests are clamped
package step_sched_pkg;

  typedef enum logic [1:0] {
    SsIdle = 2'd0,
    SsWait = 2'd1,
    SsBusy = 2'd2
  } ss_state_e;

  localparam int unsigned SsPeriodMin = 2;

endpackage

// File: rtl/step_sched_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level.
//
// Parameters:
//   STAGES - number of flops in the chain (2 or more)
// Ports:
//   clk - destination clock
//   rst - asynchronous active-low reset; clears every stage to 0
//   d   - asynchronous input level
//   q   - synchronized output, STAGES clocks behind d
module step_sched_sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/step_sched.sv
// Step scheduler and mode sequencer for the switched state-space solver.
//
// Produces a periodic one-cycle compute launch pulse, latches the switch state for each
// iteration, swaps coefficient banks only at step boundaries, tracks completion from the
// compute block and counts steps, overruns and the worst-case completion latency.
//
// Parameters:
//   CNT_W       - width of the period counter, period input and lat_max
//   STAT_W      - width of the saturating step/overrun counters
//   SYNC_STAGES - synchronizer depth on gate (2 or more)
// Ports:
//   clk          - system clock, rising edge
//   rst          - asynchronous active-low reset
//   en           - run enable
//   period       - step period in clocks; values below 2 behave as 2
//   gate         - raw switch state, asynchronous (1 = on)
//   cfg_swap_req - level request to activate the shadow coefficient bank
//   cfg_swap_ack - pulse: the bank swap took effect with this step
//   bank_sel     - active coefficient bank
//   step         - one-cycle compute launch pulse
//   sw_sel       - matrix select held for the whole iteration (1 = on matrices)
//   comp_ready   - completion strobe from the compute block
//   busy         - an iteration is in flight
//   overrun      - pulse: a tick was missed because an iteration was still in flight
//   overrun_cnt  - saturating overrun count
//   step_cnt     - saturating issued-step count
//   lat_max      - largest step-to-completion latency seen, in clocks
module step_sched
  import step_sched_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned STAT_W      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  period,
  input  logic              gate,
  input  logic              cfg_swap_req,
  output logic              cfg_swap_ack,
  output logic              bank_sel,
  output logic              step,
  output logic              sw_sel,
  input  logic              comp_ready,
  output logic              busy,
  output logic              overrun,
  output logic [STAT_W-1:0] overrun_cnt,
  output logic [STAT_W-1:0] step_cnt,
  output logic [CNT_W-1:0]  lat_max
);

  ss_state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  lat_q;
  logic [CNT_W-1:0]  lat_max_q;
  logic [STAT_W-1:0] step_cnt_q;
  logic [STAT_W-1:0] ovr_cnt_q;
  logic              step_q;
  logic              ack_q;
  logic              bank_q;
  logic              sw_sel_q;
  logic              busy_q;
  logic              overrun_q;

  logic              gate_sync;
  logic [CNT_W-1:0]  per_eff;
  logic [CNT_W-1:0]  last_cnt;
  logic              tick;
  logic              done;
  logic              issue;
  logic              miss;

  step_sched_sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_gate_sync (
    .clk (clk),
    .rst (rst),
    .d   (gate),
    .q   (gate_sync)
  );

  assign per_eff  = (period < CNT_W'(SsPeriodMin)) ? CNT_W'(SsPeriodMin) : period;
  assign last_cnt = per_eff - CNT_W'(1);

  // A >= compare lets a shortened period fire immediately instead of running the counter
  // all the way round when cnt has already passed the new terminal value.
  assign tick = en && (state_q != SsIdle) && (cnt_q >= last_cnt);

  // Completion is ignored during the launch cycle itself.
  assign done = (state_q == SsBusy) && comp_ready && !step_q;

  // Completion is processed before the tick, so a completing iteration can chain
  // straight into the next launch.
  assign issue = tick && ((state_q == SsWait) || done);
  assign miss  = tick && (state_q == SsBusy) && !done;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SsIdle: begin
        if (en) state_d = SsWait;
      end
      SsWait: begin
        if (issue)    state_d = SsBusy;
        else if (!en) state_d = SsIdle;
      end
      SsBusy: begin
        if (issue)     state_d = SsBusy;
        else if (done) state_d = en ? SsWait : SsIdle;
      end
      default: state_d = SsIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SsIdle;
      cnt_q      <= '0;
      lat_q      <= '0;
      lat_max_q  <= '0;
      step_cnt_q <= '0;
      ovr_cnt_q  <= '0;
      step_q     <= 1'b0;
      ack_q      <= 1'b0;
      bank_q     <= 1'b0;
      sw_sel_q   <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d == SsBusy);
      step_q    <= issue;
      ack_q     <= issue && cfg_swap_req;
      overrun_q <= miss;

      // Period counter: held at zero while idle or disabled, wraps on every tick.
      if (!en || (state_q == SsIdle)) begin
        cnt_q <= '0;
      end else if (tick) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (issue) begin
        sw_sel_q <= gate_sync;
        if (cfg_swap_req) bank_q <= ~bank_q;
        if (step_cnt_q != '1) step_cnt_q <= step_cnt_q + STAT_W'(1);
      end

      if (miss && (ovr_cnt_q != '1)) begin
        ovr_cnt_q <= ovr_cnt_q + STAT_W'(1);
      end

      // lat_q is 0 in the launch cycle and counts every cycle the iteration is in flight.
      if (issue) begin
        lat_q <= '0;
      end else if ((state_q == SsBusy) && (lat_q != '1)) begin
        lat_q <= lat_q + CNT_W'(1);
      end

      if (done && (lat_q > lat_max_q)) begin
        lat_max_q <= lat_q;
      end
    end
  end

  assign step         = step_q;
  assign cfg_swap_ack = ack_q;
  assign bank_sel     = bank_q;
  assign sw_sel       = sw_sel_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign overrun_cnt  = ovr_cnt_q;
  assign step_cnt     = step_cnt_q;
  assign lat_max      = lat_max_q;

endmodule

// File: tb/tb_step_sched.sv
// Randomized scoreboard bench for step_sched. A reference model predicts launch times
// from the period arithmetic (launches land on en_cycle + 1 + k*P unless the previous
// iteration is still in flight) and queues the expected launch/overrun events; a monitor
// pops them as the DUT presents step/overrun pulses.
module tb_step_sched;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned STAT_W = 5;
  localparam int unsigned SYNC   = 2;
  localparam int          MAXC   = 16384;
  localparam int          SATMAX = (1 << STAT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic [CNT_W-1:0]  period = '0;
  logic              gate = 1'b0;
  logic              cfg_swap_req = 1'b0;
  logic              cfg_swap_ack;
  logic              bank_sel;
  logic              step;
  logic              sw_sel;
  logic              comp_ready = 1'b0;
  logic              busy;
  logic              overrun;
  logic [STAT_W-1:0] overrun_cnt;
  logic [STAT_W-1:0] step_cnt;
  logic [CNT_W-1:0]  lat_max;

  step_sched #(
    .CNT_W       (CNT_W),
    .STAT_W      (STAT_W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .period       (period),
    .gate         (gate),
    .cfg_swap_req (cfg_swap_req),
    .cfg_swap_ack (cfg_swap_ack),
    .bank_sel     (bank_sel),
    .step         (step),
    .sw_sel       (sw_sel),
    .comp_ready   (comp_ready),
    .busy         (busy),
    .overrun      (overrun),
    .overrun_cnt  (overrun_cnt),
    .step_cnt     (step_cnt),
    .lat_max      (lat_max)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic sw;
    logic ack;
    logic bank;
  } step_exp_t;

  step_exp_t step_q[$];
  int        ovr_q[$];
  step_exp_t mon_e;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int   p_eff, lat_l, en_cyc, next_cand, last_step, ack_at;
  bit   in_flight;
  logic bank_m;
  int   n_steps, n_ovr, lat_m;
  logic gate_hist[MAXC];
  logic req_hist[MAXC];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SATMAX) ? SATMAX : v;
  endfunction

  // Monitor: compares DUT pulses against the queued expectations.
  always @(negedge clk) begin
    if (rst) begin
      while (step_q.size() > 0 && step_q[0].cyc < cyc) begin
        chk("step_missing", cyc, step_q[0].cyc);
        void'(step_q.pop_front());
      end
      if (step) begin
        if (step_q.size() == 0) begin
          chk("step_unexpected", step, 0);
        end else begin
          mon_e = step_q.pop_front();
          chk("step_cycle", cyc, mon_e.cyc);
          chk("sw_sel", sw_sel, mon_e.sw);
          chk("cfg_swap_ack", cfg_swap_ack, mon_e.ack);
          chk("bank_sel", bank_sel, mon_e.bank);
        end
      end else if (cfg_swap_ack) begin
        chk("ack_without_step", cfg_swap_ack, step);
      end
      while (ovr_q.size() > 0 && ovr_q[0] < cyc) begin
        chk("overrun_missing", cyc, ovr_q[0]);
        void'(ovr_q.pop_front());
      end
      if (overrun) begin
        if (ovr_q.size() == 0) begin
          chk("overrun_unexpected", overrun, 0);
        end else begin
          chk("overrun_cycle", cyc, ovr_q.pop_front());
        end
      end
    end
  end

  // One cycle of stimulus plus model update; runs at negedge + 1.
  task automatic drive_cycle();
    int c;
    step_exp_t e;
    c = cyc;
    chk("busy", busy, int'(in_flight));
    en         = (c >= en_cyc);
    comp_ready = in_flight && (c == last_step + lat_l);
    if (ack_at == c) cfg_swap_req = 1'b0;
    else if (!cfg_swap_req && en && $urandom_range(0, 24) == 0) cfg_swap_req = 1'b1;
    if (c >= en_cyc && $urandom_range(0, 6) == 0) gate = ~gate;
    gate_hist[c] = gate;
    req_hist[c]  = cfg_swap_req;

    if (in_flight && c == last_step + lat_l) begin
      in_flight = 1'b0;
      if (lat_l > lat_m) lat_m = lat_l;
    end
    if (en && c == next_cand - 1) begin
      if (!in_flight) begin
        e.cyc  = c + 1;
        e.sw   = (c - int'(SYNC) >= 0) ? gate_hist[c - int'(SYNC)] : 1'b0;
        e.ack  = req_hist[c];
        if (req_hist[c]) begin
          bank_m = ~bank_m;
          ack_at = c + 1;
        end
        e.bank = bank_m;
        step_q.push_back(e);
        in_flight = 1'b1;
        last_step = c + 1;
        n_steps++;
      end else begin
        ovr_q.push_back(c + 1);
        n_ovr++;
      end
      next_cand += p_eff;
    end
  endtask

  task automatic end_check();
    int pend;
    pend = 0;
    foreach (step_q[i]) if (step_q[i].cyc <= cyc) pend++;
    chk("steps_pending", pend, 0);
    chk("step_cnt", int'(step_cnt), sat(n_steps));
    chk("overrun_cnt", int'(overrun_cnt), sat(n_ovr));
    chk("lat_max", int'(lat_max), lat_m);
  endtask

  task automatic run_phase(input int raw_p, input int lat, input int ncyc);
    @(negedge clk);
    #1;
    rst          = 1'b0;
    en           = 1'b0;
    comp_ready   = 1'b0;
    cfg_swap_req = 1'b0;
    gate         = 1'b0;
    #1;
    chk("rst_step", step, 0);
    chk("rst_sw_sel", sw_sel, 0);
    chk("rst_bank_sel", bank_sel, 0);
    chk("rst_ack", cfg_swap_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_step_cnt", int'(step_cnt), 0);
    chk("rst_overrun_cnt", int'(overrun_cnt), 0);
    chk("rst_lat_max", int'(lat_max), 0);
    step_q.delete();
    ovr_q.delete();
    in_flight = 1'b0;
    bank_m    = 1'b0;
    n_steps   = 0;
    n_ovr     = 0;
    lat_m     = 0;
    last_step = -1000;
    ack_at    = -1;
    period    = CNT_W'(raw_p);
    p_eff     = (raw_p < 2) ? 2 : raw_p;
    lat_l     = lat;
    en_cyc    = cyc + 4;
    next_cand = en_cyc + 1 + p_eff;
    gate_hist[cyc] = 1'b0;
    req_hist[cyc]  = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
      drive_cycle();
    end
    rst = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      #1;
      drive_cycle();
    end
    @(negedge clk);
    #1;
    end_check();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    run_phase(50, 10, 1000);  // regular steps, no overrun
    run_phase(20, 30, 400);   // every other tick overruns
    run_phase(8, 7, 200);     // completion coincides with tick: chained launch
    run_phase(0, 3, 100);     // period clamp to 2
    run_phase(1, 1, 100);     // back-to-back chaining, step_cnt saturates
    run_phase(2, 40, 600);    // heavy overrun, overrun_cnt saturates
    for (int k = 0; k < 5; k++) begin
      int rp;
      int pe;
      rp = $urandom_range(0, 40);
      pe = (rp < 2) ? 2 : rp;
      run_phase(rp, $urandom_range(1, 2 * pe + 4), 300);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
